decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// RV32I decode stage with a register scoreboard.  One instruction at a time
// walks IDLE -> CHECK -> READ -> HOLD.  CHECK stalls while either source
// register is still owed a writeback.  READ captures the register file data.
// HOLD presents the decoded bundle until downstream accepts it.  The
// scoreboard bit for the destination register is set when downstream accepts
// the bundle.  It is cleared when execute writes that register back.
//
// Optional feature (macro DECODE_WB_BYPASS_EN):
//   When defined, a writeback that arrives in the same cycle as the CHECK
//   decision counts as already done.  Its value is forwarded into the operand
//   registers at READ, which saves one stall cycle per resolved hazard.
//   When undefined, CHECK waits for the registered scoreboard bit to clear.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   fetch handshake, in_instr = RV32I instruction word
//   rf_rd, rf_selrd1/2  register file read strobe and read selects
//   rf_rdval1/2         register file read data (valid the cycle after rf_rd)
//   wb_valid/sel/val    writeback request from execute
//   rf_wr/selwr/wrval   register file write port (writes to x0 are dropped)
//   out_valid/out_ready downstream handshake
//   out_*               registered decoded fields, operands and immediate
// ---------------------------------------------------------------------------
module decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        rf_rd,
   output logic [4:0]  rf_selrd1,
   output logic [4:0]  rf_selrd2,
   input  logic [31:0] rf_rdval1,
   input  logic [31:0] rf_rdval2,
   input  logic        wb_valid,
   input  logic [4:0]  wb_sel,
   input  logic [31:0] wb_val,
   output logic        rf_wr,
   output logic [4:0]  rf_selwr,
   output logic [31:0] rf_wrval,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [6:0]  out_opcode,
   output logic [2:0]  out_funct3,
   output logic [6:0]  out_funct7,
   output logic [4:0]  out_rd,
   output logic [31:0] out_rs1val,
   output logic [31:0] out_rs2val,
   output logic [31:0] out_imm
);

   typedef enum logic [1:0] {IDLE, CHECK, READ, HOLD} state_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t      state, next_state;
   logic [31:0] busy, busy_next, busy_eff, wb_mask;
   logic [4:0]  rs1_q, rs2_q;
   logic        accept, advance, hold_fire, hazard, uses_rs, wb_clear, set_en;

   // Sign-extended immediate for each instruction format.  Opcodes that carry
   // no immediate give zero.
   function automatic logic [31:0] imm_of(input logic [31:0] i);
      logic [31:0] imm;
      imm = '0;
      case (i[6:0])
         OP_IMM, OP_LOAD, OP_JALR: imm = {{20{i[31]}}, i[31:20]};
         OP_STORE:                 imm = {{20{i[31]}}, i[31:25], i[11:7]};
         OP_BRANCH:                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         imm = {i[31:12], 12'b0};
         OP_JAL:                   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default:                  imm = '0;
      endcase
      return imm;
   endfunction

   // The register file write port passes straight through.  It is held off
   // during reset, and writes to x0 are dropped.
   assign wb_clear = wb_valid && (wb_sel != 5'd0);
   assign rf_wr    = rst && wb_clear;
   assign rf_selwr = rst ? wb_sel : 5'd0;
   assign rf_wrval = rst ? wb_val : 32'd0;
   assign wb_mask  = wb_clear ? (32'd1 << wb_sel) : 32'd0;

   // U and J formats have no source registers.  Their rs bit positions hold
   // immediate bits, so they must not cause a stall.
   assign uses_rs = !((out_opcode == OP_LUI) || (out_opcode == OP_AUIPC) ||
                      (out_opcode == OP_JAL));

`ifdef DECODE_WB_BYPASS_EN
   // A writeback arriving this cycle already counts as a free register.
   assign busy_eff = busy & ~wb_mask;
`else
   assign busy_eff = busy;
`endif

   assign hazard = uses_rs && (busy_eff[rs1_q] || busy_eff[rs2_q]);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Next-state and handshake decode.  The read strobe is issued from CHECK
   // only once both sources are clear.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      rf_rd      = 1'b0;
      rf_selrd1  = 5'd0;
      rf_selrd2  = 5'd0;
      accept     = 1'b0;
      advance    = 1'b0;
      hold_fire  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               next_state = CHECK;
            end
         end
         CHECK: begin
            rf_selrd1 = rs1_q;
            rf_selrd2 = rs2_q;
            if (!hazard) begin
               rf_rd      = 1'b1;
               advance    = 1'b1;
               next_state = READ;
            end
         end
         READ: next_state = HOLD;
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               hold_fire  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Scoreboard update.  The writeback clear is applied first, so a
   // destination set in the same cycle wins.  Bit 0 is never busy.
   always_comb begin
      set_en = hold_fire && (out_rd != 5'd0) &&
               (out_opcode != OP_STORE) && (out_opcode != OP_BRANCH);
      busy_next = busy & ~wb_mask;
      if (set_en) busy_next[out_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= '0;
      else      busy <= busy_next;
   end

`ifdef DECODE_WB_BYPASS_EN
   logic        fwd1_q, fwd2_q;
   logic [31:0] fwdval_q;

   // Remember any writeback that resolved a source in the CHECK cycle.  The
   // register file read issued in that same cycle may not see the new value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwd1_q   <= 1'b0;
         fwd2_q   <= 1'b0;
         fwdval_q <= '0;
      end else if (advance) begin
         fwd1_q   <= wb_clear && (wb_sel == rs1_q);
         fwd2_q   <= wb_clear && (wb_sel == rs2_q);
         fwdval_q <= wb_val;
      end
   end
`endif

   // Decoded fields are captured when the instruction is accepted.  The
   // operands are captured in READ.  Everything is held unchanged through HOLD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs1_q      <= '0;
         rs2_q      <= '0;
         out_opcode <= '0;
         out_funct3 <= '0;
         out_funct7 <= '0;
         out_rd     <= '0;
         out_imm    <= '0;
         out_rs1val <= '0;
         out_rs2val <= '0;
      end else begin
         if (accept) begin
            rs1_q      <= in_instr[19:15];
            rs2_q      <= in_instr[24:20];
            out_opcode <= in_instr[6:0];
            out_funct3 <= in_instr[14:12];
            out_funct7 <= in_instr[31:25];
            out_rd     <= in_instr[11:7];
            out_imm    <= imm_of(in_instr);
         end
         if (state == READ) begin
`ifdef DECODE_WB_BYPASS_EN
            out_rs1val <= fwd1_q ? fwdval_q : rf_rdval1;
            out_rs2val <= fwd2_q ? fwdval_q : rf_rdval2;
`else
            out_rs1val <= rf_rdval1;
            out_rs2val <= rf_rdval2;
`endif
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Directed testbench for decode_stage in its default build (no writeback
// bypass).  A single linear sequence drives hand-encoded RV32I words and
// compares the outputs against hand-computed values one step after each
// rising edge.
// ---------------------------------------------------------------------------
module tb_decode_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        rf_rd;
   logic [4:0]  rf_selrd1, rf_selrd2;
   logic [31:0] rf_rdval1, rf_rdval2;
   logic        wb_valid;
   logic [4:0]  wb_sel;
   logic [31:0] wb_val;
   logic        rf_wr;
   logic [4:0]  rf_selwr;
   logic [31:0] rf_wrval;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [4:0]  out_rd;
   logic [31:0] out_rs1val, out_rs2val, out_imm;

   int errors = 0;
   int checks = 0;

   decode_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .rf_rd(rf_rd), .rf_selrd1(rf_selrd1), .rf_selrd2(rf_selrd2),
      .rf_rdval1(rf_rdval1), .rf_rdval2(rf_rdval2),
      .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_val(wb_val),
      .rf_wr(rf_wr), .rf_selwr(rf_selwr), .rf_wrval(rf_wrval),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_rd(out_rd), .out_rs1val(out_rs1val), .out_rs2val(out_rs2val),
      .out_imm(out_imm)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance the given number of rising edges and settle just past the last one.
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One comparison point.  A mismatch is counted and reported.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Directed sequence.
   initial begin
      rst = 1'b0; in_valid = 1'b0; in_instr = '0;
      rf_rdval1 = '0; rf_rdval2 = '0;
      wb_valid = 1'b1; wb_sel = 5'd5; wb_val = 32'd123;
      out_ready = 1'b0;
      applyStimulus(2);

      // Reset state.  A writeback request during reset must not reach the
      // register file.
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_rf_rd",     {31'd0, rf_rd},     32'd0);
      checkOutput("rst_rf_wr",     {31'd0, rf_wr},     32'd0);
      checkOutput("rst_rf_selwr",  {27'd0, rf_selwr},  32'd0);
      checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
      checkOutput("rst_out_imm",   out_imm,            32'd0);
      wb_valid = 1'b0; wb_sel = 5'd0; wb_val = '0;
      rst = 1'b1;
      applyStimulus(1);

      // addi x1,x0,10: read at N+1, out_valid at N+3.
      in_instr = 32'h00A00093; in_valid = 1'b1; #1;
      checkOutput("addi_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(1);
      in_valid = 1'b0;
      checkOutput("addi_rf_rd_n1",  {31'd0, rf_rd},     32'd1);
      checkOutput("addi_selrd1",    {27'd0, rf_selrd1}, 32'd0);
      checkOutput("addi_selrd2",    {27'd0, rf_selrd2}, 32'd10);
      checkOutput("addi_check_inr", {31'd0, in_ready},  32'd0);
      rf_rdval1 = 32'd0; rf_rdval2 = 32'h55;
      applyStimulus(1);
      checkOutput("addi_rf_rd_n2",  {31'd0, rf_rd},     32'd0);
      checkOutput("addi_ovalid_n2", {31'd0, out_valid}, 32'd0);
      applyStimulus(1);
      checkOutput("addi_ovalid_n3", {31'd0, out_valid}, 32'd1);
      checkOutput("addi_imm",       out_imm,            32'd10);
      checkOutput("addi_rd",        {27'd0, out_rd},    32'd1);
      checkOutput("addi_opcode",    {25'd0, out_opcode}, 32'h13);
      checkOutput("addi_rs1val",    out_rs1val,         32'd0);
      out_ready = 1'b1;
      applyStimulus(1);
      out_ready = 1'b0;
      checkOutput("addi_done_ovalid", {31'd0, out_valid}, 32'd0);
      checkOutput("addi_done_inr",    {31'd0, in_ready},  32'd1);

      // add x3,x1,x2 stalls on x1 until the writeback has been registered.
      in_instr = 32'h002081B3; in_valid = 1'b1;
      applyStimulus(1);
      in_valid = 1'b0;
      checkOutput("add_stall0", {31'd0, rf_rd}, 32'd0);
      applyStimulus(2);
      checkOutput("add_stall2",        {31'd0, rf_rd},     32'd0);
      checkOutput("add_stall2_ovalid", {31'd0, out_valid}, 32'd0);
      wb_valid = 1'b1; wb_sel = 5'd1; wb_val = 32'd10; #1;
      checkOutput("wb1_rf_wr",    {31'd0, rf_wr},    32'd1);
      checkOutput("wb1_selwr",    {27'd0, rf_selwr}, 32'd1);
      checkOutput("wb1_wrval",    rf_wrval,          32'd10);
      checkOutput("wb1_no_rf_rd", {31'd0, rf_rd},    32'd0);
      applyStimulus(1);
      wb_valid = 1'b0; #1;
      checkOutput("add_go_rf_rd", {31'd0, rf_rd},     32'd1);
      checkOutput("add_selrd1",   {27'd0, rf_selrd1}, 32'd1);
      checkOutput("add_selrd2",   {27'd0, rf_selrd2}, 32'd2);
      rf_rdval1 = 32'd10; rf_rdval2 = 32'd7;
      applyStimulus(2);
      checkOutput("add_ovalid",  {31'd0, out_valid}, 32'd1);
      checkOutput("add_rs1val",  out_rs1val,         32'd10);
      checkOutput("add_rs2val",  out_rs2val,         32'd7);
      checkOutput("add_rd",      {27'd0, out_rd},    32'd3);
      checkOutput("add_imm",     out_imm,            32'd0);
      checkOutput("add_opcode",  {25'd0, out_opcode}, 32'h33);
      rf_rdval1 = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1);
         checkOutput("hold_ovalid",  {31'd0, out_valid}, 32'd1);
         checkOutput("hold_inready", {31'd0, in_ready},  32'd0);
         checkOutput("hold_rs1val",  out_rs1val,         32'd10);
      end
      out_ready = 1'b1;
      applyStimulus(1);
      out_ready = 1'b0;

      // A writeback to x0 is dropped.  A writeback to x3 passes through and
      // frees x3.
      wb_valid = 1'b1; wb_sel = 5'd0; wb_val = 32'hFFFFFFFF; #1;
      checkOutput("wb0_rf_wr", {31'd0, rf_wr}, 32'd0);
      wb_sel = 5'd3; wb_val = 32'd77; #1;
      checkOutput("wb3_rf_wr",  {31'd0, rf_wr}, 32'd1);
      checkOutput("wb3_wrval",  rf_wrval,       32'd77);
      applyStimulus(1);
      wb_valid = 1'b0;

      // sw x2,-4(x1): S-format immediate, and no destination to mark busy.
      in_instr = 32'hFE20AE23; in_valid = 1'b1;
      applyStimulus(1);
      in_valid = 1'b0;
      checkOutput("sw_rf_rd",   {31'd0, rf_rd},     32'd1);
      checkOutput("sw_selrd1",  {27'd0, rf_selrd1}, 32'd1);
      checkOutput("sw_selrd2",  {27'd0, rf_selrd2}, 32'd2);
      rf_rdval1 = 32'h100; rf_rdval2 = 32'h22;
      applyStimulus(2);
      checkOutput("sw_imm",     out_imm,              32'hFFFFFFFC);
      checkOutput("sw_funct3",  {29'd0, out_funct3},  32'd2);
      checkOutput("sw_funct7",  {25'd0, out_funct7},  32'h7F);
      checkOutput("sw_rs2val",  out_rs2val,           32'h22);
      out_ready = 1'b1;
      applyStimulus(1);
      out_ready = 1'b0;

      // addi x1 accepted downstream in the same cycle as a writeback to x1.
      // The set wins, so the following add x3,x1,x2 must stall.
      in_instr = 32'h00A00093; in_valid = 1'b1;
      applyStimulus(1);
      in_valid = 1'b0;
      applyStimulus(2);
      checkOutput("same_ovalid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1; wb_valid = 1'b1; wb_sel = 5'd1; wb_val = 32'd99;
      applyStimulus(1);
      out_ready = 1'b0; wb_valid = 1'b0;
      in_instr = 32'h002081B3; in_valid = 1'b1;
      applyStimulus(1);
      in_valid = 1'b0;
      checkOutput("same_busy1_stall0", {31'd0, rf_rd}, 32'd0);
      applyStimulus(1);
      checkOutput("same_busy1_stall1", {31'd0, rf_rd}, 32'd0);
      wb_valid = 1'b1; wb_sel = 5'd1; wb_val = 32'd10;
      applyStimulus(1);
      wb_valid = 1'b0; #1;
      checkOutput("same_release", {31'd0, rf_rd}, 32'd1);
      rf_rdval1 = 32'd10; rf_rdval2 = 32'd7;
      applyStimulus(2);
      out_ready = 1'b1;
      applyStimulus(1);
      out_ready = 1'b0;

      // lui x7,0x12345: its rs2 bit position reads as x3, which is busy, but a
      // U-format instruction has no sources and must not stall.
      in_instr = 32'h123453B7; in_valid = 1'b1;
      applyStimulus(1);
      in_valid = 1'b0;
      checkOutput("lui_no_stall", {31'd0, rf_rd}, 32'd1);
      applyStimulus(2);
      checkOutput("lui_imm", out_imm,          32'h12345000);
      checkOutput("lui_rd",  {27'd0, out_rd},  32'd7);
      out_ready = 1'b1;
      applyStimulus(1);
      out_ready = 1'b0;

      // add x5,x28,x0: x28 must be free because the store did not mark it.
      in_instr = 32'h000E02B3; in_valid = 1'b1;
      applyStimulus(1);
      in_valid = 1'b0;
      checkOutput("x28_free_rf_rd", {31'd0, rf_rd},     32'd1);
      checkOutput("x28_selrd1",     {27'd0, rf_selrd1}, 32'd28);
      rf_rdval1 = 32'hABC; rf_rdval2 = 32'd0;
      applyStimulus(2);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold2_ovalid",  {31'd0, out_valid}, 32'd1);
         checkOutput("hold2_inready", {31'd0, in_ready},  32'd0);
         checkOutput("hold2_rs1val",  out_rs1val,         32'hABC);
         checkOutput("hold2_rd",      {27'd0, out_rd},    32'd5);
         applyStimulus(1);
      end

      // Reset in the middle of HOLD takes effect without waiting for a clock.
      rst = 1'b0; #1;
      checkOutput("midrst_ovalid",  {31'd0, out_valid}, 32'd0);
      checkOutput("midrst_rd",      {27'd0, out_rd},    32'd0);
      checkOutput("midrst_rs1val",  out_rs1val,         32'd0);
      checkOutput("midrst_opcode",  {25'd0, out_opcode}, 32'd0);
      checkOutput("midrst_inready", {31'd0, in_ready},  32'd1);
      applyStimulus(1);
      rst = 1'b1;
      applyStimulus(1);

      // x3 was busy before the reset.  The scoreboard is now clear, so
      // add x6,x3,x0 issues its read without stalling.
      in_instr = 32'h00018333; in_valid = 1'b1;
      applyStimulus(1);
      in_valid = 1'b0;
      checkOutput("postrst_rf_rd",  {31'd0, rf_rd},     32'd1);
      checkOutput("postrst_selrd1", {27'd0, rf_selrd1}, 32'd3);
      rf_rdval1 = 32'd5;
      applyStimulus(2);
      checkOutput("postrst_rd",      {27'd0, out_rd}, 32'd6);
      checkOutput("postrst_rs1val",  out_rs1val,      32'd5);
      out_ready = 1'b1;
      applyStimulus(1);
      out_ready = 1'b0;
      checkOutput("postrst_done", {31'd0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
